// File: rtl/fused_mac_pipe_acc.sv
// fused_mac_pipe_acc
// This is a two-stage signed multiply-accumulate pipeline. It has two modes:
//   - full mode: a single A_W x B_W product is accumulated into a FULL_W
//     accumulator. That accumulator is sign-extended onto `out`.
//   - split mode: `b` holds two signed halves. Each half is multiplied by `a`
//     and accumulated into its own LANE_W lane. No carry crosses between lanes.
// The accumulator is cleared when a beat carries `clr`, and also when a beat's
// mode differs from the mode of the previous accumulated beat.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   an input beat is offered
//   in_ready   the block accepts the beat this cycle
//   a          signed multiplicand (A_W bits)
//   b          signed multiplier (B_W bits), or two signed halves in split mode
//   split      1 = two lanes, 0 = one full-width product
//   clr        this beat accumulates from zero
//   out_valid  a new accumulation result is present on `out`
//   out_ready  the consumer takes the result
//   out        accumulator contents (2*LANE_W bits)
//   ovf        sticky signed-overflow flag
//
// Parameter constraints: B_W must be even, A_W+B_W <= FULL_W <= 2*LANE_W,
// and LANE_W >= A_W+B_W/2.

module fused_mac_pipe_acc #(
  parameter int A_W    = 8,
  parameter int B_W    = 8,
  parameter int FULL_W = 32,
  parameter int LANE_W = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [A_W-1:0]        a,
  input  logic [B_W-1:0]        b,
  input  logic                  split,
  input  logic                  clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*LANE_W-1:0]   out,
  output logic                  ovf
);

  localparam int H_W   = B_W / 2;
  localparam int P_W   = A_W + B_W;
  localparam int PH_W  = A_W + H_W;
  localparam int OUT_W = 2 * LANE_W;

  // ---------------------------------------------------------------------------
  // Product generation (combinational, registered in stage 1)
  // ---------------------------------------------------------------------------
  logic signed [A_W-1:0]  a_s;
  logic signed [B_W-1:0]  b_s;
  logic signed [H_W-1:0]  b_lo;
  logic signed [H_W-1:0]  b_hi;
  logic signed [P_W-1:0]  prod_full;
  logic signed [PH_W-1:0] prod_lo;
  logic signed [PH_W-1:0] prod_hi;

  assign a_s  = a;
  assign b_s  = b;
  assign b_lo = b[H_W-1:0];
  assign b_hi = b[B_W-1:H_W];

  // Both operands are widened to the product width before multiplying.
  // This keeps the multiply signed and exact.
  assign prod_full = P_W'(a_s) * P_W'(b_s);
  assign prod_lo   = PH_W'(a_s) * PH_W'(b_lo);
  assign prod_hi   = PH_W'(a_s) * PH_W'(b_hi);

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid;
  logic s1_split;
  logic s1_clr;
  logic signed [P_W-1:0]  s1_full;
  logic signed [PH_W-1:0] s1_lo;
  logic signed [PH_W-1:0] s1_hi;
  logic prev_split;
  logic load_s2;
  logic accept;

  // Stage 1 drains whenever the accumulator is free or is being read this
  // cycle. The input is blocked only when both stages hold data and the
  // output is stalled. This is built from registers and out_ready only,
  // so in_valid has no combinational path to in_ready.
  assign load_s2  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !(s1_valid && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Accumulate arithmetic
  // ---------------------------------------------------------------------------
  logic                     base_zero;
  logic signed [FULL_W-1:0] base_full;
  logic signed [FULL_W-1:0] add_full;
  logic signed [FULL_W-1:0] sum_full;
  logic signed [LANE_W-1:0] base_lo;
  logic signed [LANE_W-1:0] base_hi;
  logic signed [LANE_W-1:0] add_lo;
  logic signed [LANE_W-1:0] add_hi;
  logic signed [LANE_W-1:0] sum_lo;
  logic signed [LANE_W-1:0] sum_hi;
  logic                     ovf_full;
  logic                     ovf_lo;
  logic                     ovf_hi;
  logic                     beat_ovf;
  logic [OUT_W-1:0]         next_out;

  // A change of mode restarts accumulation, exactly as clr does. The value
  // held in the other mode's layout has no meaning in this mode.
  assign base_zero = s1_clr || (s1_split != prev_split);

  assign base_full = base_zero ? '0 : out[FULL_W-1:0];
  assign base_lo   = base_zero ? '0 : out[LANE_W-1:0];
  assign base_hi   = base_zero ? '0 : out[OUT_W-1:LANE_W];

  assign add_full = FULL_W'(s1_full);
  assign add_lo   = LANE_W'(s1_lo);
  assign add_hi   = LANE_W'(s1_hi);

  assign sum_full = base_full + add_full;
  assign sum_lo   = base_lo + add_lo;
  assign sum_hi   = base_hi + add_hi;

  // Signed overflow occurs when both operands have the same sign and the
  // sign of the sum differs from it.
  assign ovf_full = (base_full[FULL_W-1] == add_full[FULL_W-1]) &&
                    (sum_full[FULL_W-1] != base_full[FULL_W-1]);
  assign ovf_lo   = (base_lo[LANE_W-1] == add_lo[LANE_W-1]) &&
                    (sum_lo[LANE_W-1] != base_lo[LANE_W-1]);
  assign ovf_hi   = (base_hi[LANE_W-1] == add_hi[LANE_W-1]) &&
                    (sum_hi[LANE_W-1] != base_hi[LANE_W-1]);

  assign beat_ovf = s1_split ? (ovf_lo || ovf_hi) : ovf_full;
  assign next_out = s1_split ? {sum_hi, sum_lo} : OUT_W'(sum_full);

  // ---------------------------------------------------------------------------
  // Stage 1: registered products plus the beat's control bits
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_split <= 1'b0;
      s1_clr   <= 1'b0;
      s1_full  <= '0;
      s1_lo    <= '0;
      s1_hi    <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_split <= split;
        s1_clr   <= clr;
        s1_full  <= prod_full;
        s1_lo    <= prod_lo;
        s1_hi    <= prod_hi;
      end else if (load_s2) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: accumulator register, which drives `out` directly
  // ---------------------------------------------------------------------------
  // The accumulator keeps its value after being read. Only out_valid drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out        <= '0;
      ovf        <= 1'b0;
      out_valid  <= 1'b0;
      prev_split <= 1'b0;
    end else if (load_s2) begin
      out        <= next_out;
      ovf        <= base_zero ? beat_ovf : (ovf || beat_ovf);
      out_valid  <= 1'b1;
      prev_split <= s1_split;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fused_mac_pipe_acc.sv
// tb_fused_mac_pipe_acc
// This bench drives two instances of fused_mac_pipe_acc:
//   - inst 0 uses the default widths.
//   - inst 1 uses FULL_W=16 and LANE_W=12, so overflow is reachable.
// Accepted beats are fed to an arithmetic reference model, which pushes
// expected results into a per-instance queue. A negedge monitor pops and
// compares each time a result handshake is presented.

module tb_fused_mac_pipe_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        v0, sp0, cl0, ordy0, irdy0, ovalid0, ovf0;
  logic [7:0]  a0, b0;
  logic [47:0] out0;

  logic        v1, sp1, cl1, ordy1, irdy1, ovalid1, ovf1;
  logic [7:0]  a1, b1;
  logic [23:0] out1;

  fused_mac_pipe_acc dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(irdy0),
    .a(a0), .b(b0), .split(sp0), .clr(cl0),
    .out_valid(ovalid0), .out_ready(ordy0), .out(out0), .ovf(ovf0)
  );

  fused_mac_pipe_acc #(.A_W(8), .B_W(8), .FULL_W(16), .LANE_W(12)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(irdy1),
    .a(a1), .b(b1), .split(sp1), .clr(cl1),
    .out_valid(ovalid1), .out_ready(ordy1), .out(out1), .ovf(ovf1)
  );

  typedef struct {
    logic [63:0] val;
    bit          ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e;

  int errors = 0;
  int checks = 0;

  longint m_full[2] = '{0, 0};
  longint m_lo[2]   = '{0, 0};
  longint m_hi[2]   = '{0, 0};
  bit     m_prev[2] = '{0, 0};
  bit     m_ovf[2]  = '{0, 0};
  int     acc_cnt[2] = '{0, 0};

  // Reduce v modulo 2^w and return it as a signed w-bit value.
  function automatic longint wrapSigned(input longint v, input int w);
    longint span;
    longint m;
    span = longint'(1) << w;
    m = v & (span - 1);
    if (m >= (span >> 1)) m = m - span;
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference model. It works on unbounded integers, and an overflow is
  // detected when the wrapped result differs from the exact sum.
  task automatic modelStep(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic split, input logic clr);
    longint pa, pb, blo, bhi, t0, t1, w0, w1, mask, lmask;
    int fw, lw;
    bit bz, ov;
    exp_t e;
    fw = (i == 0) ? 32 : 16;
    lw = (i == 0) ? 24 : 12;
    pa  = wrapSigned(longint'(a), 8);
    pb  = wrapSigned(longint'(b), 8);
    blo = wrapSigned(longint'(b[3:0]), 4);
    bhi = wrapSigned(longint'(b[7:4]), 4);
    bz  = clr || (split != m_prev[i]);
    mask  = (longint'(1) << (2 * lw)) - 1;
    lmask = (longint'(1) << lw) - 1;
    if (!split) begin
      t0 = (bz ? longint'(0) : m_full[i]) + pa * pb;
      w0 = wrapSigned(t0, fw);
      ov = (w0 != t0);
      m_full[i] = w0;
      e.val = 64'(w0 & mask);
    end else begin
      t0 = (bz ? longint'(0) : m_lo[i]) + pa * blo;
      t1 = (bz ? longint'(0) : m_hi[i]) + pa * bhi;
      w0 = wrapSigned(t0, lw);
      w1 = wrapSigned(t1, lw);
      ov = (w0 != t0) || (w1 != t1);
      m_lo[i] = w0;
      m_hi[i] = w1;
      e.val = 64'(((w1 & lmask) << lw) | (w0 & lmask));
    end
    m_ovf[i]  = bz ? ov : (m_ovf[i] | ov);
    e.ovf     = m_ovf[i];
    m_prev[i] = split;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor. Inputs change just after the rising edge, so at the negedge
  // all handshake signals are settled for the upcoming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) begin
        m_full[i] = 0; m_lo[i] = 0; m_hi[i] = 0; m_prev[i] = 0; m_ovf[i] = 0;
      end
    end else begin
      if (ovalid0 && ordy0) begin
        checkOutput("sb_pending0", 64'(q0.size() > 0), 64'd1);
        if (q0.size() > 0) begin
          mon_e = q0.pop_front();
          checkOutput("sb_out0", 64'(out0), mon_e.val);
          checkOutput("sb_ovf0", 64'(ovf0), 64'(mon_e.ovf));
        end
      end
      if (ovalid1 && ordy1) begin
        checkOutput("sb_pending1", 64'(q1.size() > 0), 64'd1);
        if (q1.size() > 0) begin
          mon_e = q1.pop_front();
          checkOutput("sb_out1", 64'(out1), mon_e.val);
          checkOutput("sb_ovf1", 64'(ovf1), 64'(mon_e.ovf));
        end
      end
      if (v0 && irdy0) begin
        modelStep(0, a0, b0, sp0, cl0);
        acc_cnt[0]++;
      end
      if (v1 && irdy1) begin
        modelStep(1, a1, b1, sp1, cl1);
        acc_cnt[1]++;
      end
    end
  end

  task automatic applyStimulus(input int i, input logic v, input logic [7:0] a,
                               input logic [7:0] b, input logic split, input logic clr);
    if (i == 0) begin
      v0 = v; a0 = a; b0 = b; sp0 = split; cl0 = clr;
    end else begin
      v1 = v; a1 = a; b1 = b; sp1 = split; cl1 = clr;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int base;
    logic split_r0, split_r1;
    rst_n = 1'b0;
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0);
    applyStimulus(1, 0, 8'h00, 8'h00, 0, 0);
    ordy0 = 1'b1;
    ordy1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready0", 64'(irdy0), 64'd1);
    checkOutput("rst_out_valid0", 64'(ovalid0), 64'd0);
    checkOutput("rst_out0", 64'(out0), 64'd0);
    checkOutput("rst_ovf0", 64'(ovf0), 64'd0);
    checkOutput("rst_in_ready1", 64'(irdy1), 64'd1);
    tick();

    // Full mode, back-to-back beats
    applyStimulus(0, 1, 8'hFD, 8'h05, 0, 1);
    tick();
    applyStimulus(0, 1, 8'h02, 8'h03, 0, 0);
    tick();
    checkOutput("full_first", 64'(out0), 64'h0000_FFFF_FFFF_FFF1);
    checkOutput("full_first_valid", 64'(ovalid0), 64'd1);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0);
    tick();
    checkOutput("full_second", 64'(out0), 64'h0000_FFFF_FFFF_FFF7);
    checkOutput("full_ovf", 64'(ovf0), 64'd0);

    // Split mode, two identical beats
    applyStimulus(0, 1, 8'h07, 8'h3F, 1, 1);
    tick();
    applyStimulus(0, 1, 8'h07, 8'h3F, 1, 0);
    tick();
    checkOutput("split_first", 64'(out0), 64'h0000_0000_15FF_FFF9);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0);
    tick();
    checkOutput("split_second", 64'(out0), 64'h0000_0000_2AFF_FFF2);

    // Mode change without clr must restart from zero
    applyStimulus(0, 1, 8'h01, 8'h01, 0, 0);
    tick();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0);
    tick();
    checkOutput("mode_change", 64'(out0), 64'd1);

    // Overflow on the narrow instance
    applyStimulus(1, 1, 8'h80, 8'h80, 0, 1);
    tick();
    applyStimulus(1, 1, 8'h80, 8'h80, 0, 0);
    tick();
    checkOutput("ovf_first", 64'(out1), 64'h4000);
    checkOutput("ovf_first_flag", 64'(ovf1), 64'd0);
    tick();
    checkOutput("ovf_second", 64'(out1), 64'hFF8000);
    checkOutput("ovf_second_flag", 64'(ovf1), 64'd1);
    tick();
    checkOutput("ovf_third", 64'(out1), 64'hFFC000);
    applyStimulus(1, 0, 8'h00, 8'h00, 0, 0);
    tick();
    checkOutput("ovf_fourth", 64'(out1), 64'h000000);
    checkOutput("ovf_sticky", 64'(ovf1), 64'd1);
    applyStimulus(1, 1, 8'h01, 8'h01, 0, 1);
    tick();
    applyStimulus(1, 0, 8'h00, 8'h00, 0, 0);
    tick();
    checkOutput("ovf_clr_out", 64'(out1), 64'd1);
    checkOutput("ovf_clr_flag", 64'(ovf1), 64'd0);
    tick();

    // Backpressure: three beats offered while the output is stalled
    ordy0 = 1'b0;
    base = acc_cnt[0];
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 8'(i + 1), 8'(i + 2), 0, (i == 0));
      tick();
    end
    checkOutput("bp_accepted", 64'(acc_cnt[0] - base), 64'd2);
    checkOutput("bp_in_ready", 64'(irdy0), 64'd0);
    ordy0 = 1'b1;
    tick();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0);
    checkOutput("bp_accepted_all", 64'(acc_cnt[0] - base), 64'd3);
    repeat (4) tick();
    checkOutput("bp_final_sum", 64'(out0), 64'd20);

    // Reset with beats in both stages
    applyStimulus(1, 1, 8'h80, 8'h80, 0, 1);
    tick();
    applyStimulus(1, 1, 8'h80, 8'h80, 0, 0);
    tick();
    applyStimulus(1, 0, 8'h00, 8'h00, 0, 0);
    repeat (2) tick();
    ordy0 = 1'b0;
    ordy1 = 1'b0;
    applyStimulus(0, 1, 8'h05, 8'h05, 0, 0);
    applyStimulus(1, 1, 8'h01, 8'h01, 0, 0);
    repeat (2) tick();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0);
    applyStimulus(1, 0, 8'h00, 8'h00, 0, 0);
    checkOutput("pre_rst_ovf1", 64'(ovf1), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("mid_rst_out0", 64'(out0), 64'd0);
    checkOutput("mid_rst_valid0", 64'(ovalid0), 64'd0);
    checkOutput("mid_rst_ovf0", 64'(ovf0), 64'd0);
    checkOutput("mid_rst_in_ready0", 64'(irdy0), 64'd1);
    checkOutput("mid_rst_out1", 64'(out1), 64'd0);
    checkOutput("mid_rst_ovf1", 64'(ovf1), 64'd0);
    checkOutput("mid_rst_in_ready1", 64'(irdy1), 64'd1);
    ordy0 = 1'b1;
    ordy1 = 1'b1;
    repeat (3) tick();
    checkOutput("no_stale0", 64'(ovalid0), 64'd0);
    checkOutput("no_stale1", 64'(ovalid1), 64'd0);
    applyStimulus(0, 1, 8'h03, 8'h03, 0, 0);
    tick();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0);
    tick();
    checkOutput("post_rst_beat", 64'(out0), 64'd9);

    // Randomized traffic on both instances
    split_r0 = 1'b0;
    split_r1 = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) split_r0 = !split_r0;
      if ($urandom_range(0, 7) == 0) split_r1 = !split_r1;
      applyStimulus(0, ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                    split_r0, ($urandom_range(0, 15) == 0));
      applyStimulus(1, ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                    split_r1, ($urandom_range(0, 15) == 0));
      ordy0 = ($urandom_range(0, 3) != 0);
      ordy1 = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Drain everything still in flight
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0);
    applyStimulus(1, 0, 8'h00, 8'h00, 0, 0);
    ordy0 = 1'b1;
    ordy1 = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      tick();
    end
    checkOutput("drain_q0", 64'(q0.size()), 64'd0);
    checkOutput("drain_q1", 64'(q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
